// File: rtl/alu_iter.sv
// RV32I register-register ALU with an iterative shifter and valid/ready handshakes on both sides.
// Optional build macro ALU_ITER_SLT_EN enables SLT/SLTU; when undefined those ops return 0.
module alu_iter #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            z,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]      state;
  logic [XLEN-1:0] work;
  logic [SHW-1:0]  rem;
  logic            op_left;
  logic            op_arith;

  logic            accept;
  logic            drain;
  logic            is_shift;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [SHW:0]    s_step;
  logic [SHW-1:0]  rem_nxt;
  logic [XLEN-1:0] work_nxt;
  logic            unused_funct7;

  function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] v,
                                               input logic [SHW:0]    s,
                                               input logic            left,
                                               input logic            arith);
    logic signed [XLEN-1:0] sv;
    logic signed [XLEN-1:0] sr;
    sv = v;
    sr = sv >>> s;
    if (left)       return v << s;
    else if (arith) return sr;
    else            return v >> s;
  endfunction

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign busy     = (state == SHIFT);
  assign is_shift = (funct3[1:0] == 2'b01);
  assign shamt    = rs2[SHW-1:0];

`ifdef ALU_ITER_SLT_EN
  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   lt_s;
  logic                   lt_u;
  assign rs1_s = rs1;
  assign rs2_s = rs2;
  assign lt_s  = rs1_s < rs2_s;
  assign lt_u  = rs1 < rs2;
`endif

  // Single-cycle path: shifts only reach here with shamt=0, so rs1 passes through.
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:         alu_res = funct7[5] ? (rs1 - rs2) : (rs1 + rs2);
      3'b001, 3'b101: alu_res = rs1;
`ifdef ALU_ITER_SLT_EN
      3'b010:         alu_res = {{(XLEN-1){1'b0}}, lt_s};
      3'b011:         alu_res = {{(XLEN-1){1'b0}}, lt_u};
`endif
      3'b100:         alu_res = rs1 ^ rs2;
      3'b110:         alu_res = rs1 | rs2;
      3'b111:         alu_res = rs1 & rs2;
      default:        alu_res = '0;
    endcase
  end

  // Iterative shift step: move min(SHIFT_STEP, rem) positions.
  assign s_step   = ({1'b0, rem} < STEP) ? {1'b0, rem} : STEP;
  assign rem_nxt  = rem - s_step[SHW-1:0];
  assign work_nxt = shift_by(work, s_step, op_left, op_arith);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      rd        <= '0;
      z         <= 1'b1;
      rem       <= '0;
    end else begin
      if (drain) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              state <= SHIFT;
              rem   <= shamt;
            end else begin
              rd        <= alu_res;
              z         <= (alu_res == '0);
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          rem <= rem_nxt;
          if (rem_nxt == '0) begin
            rd        <= work_nxt;
            z         <= (work_nxt == '0);
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shifter datapath carries no reset; it is reloaded on every shift accept.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && accept && is_shift) begin
      work     <= rs1;
      op_left  <= ~funct3[2];
      op_arith <= funct7[5];
    end else if (state == SHIFT) begin
      work <= work_nxt;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: SHIFT_STEP=1 instance for most scenarios, SHIFT_STEP=4 for shift latency.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, z, busy;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1, rs2, rd;

  logic        s4_in_valid, s4_in_ready, s4_out_valid, s4_out_ready, s4_z, s4_busy;
  logic [2:0]  s4_funct3;
  logic [6:0]  s4_funct7;
  logic [31:0] s4_rs1, s4_rs2, s4_rd;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          drain_cyc[$];
  logic [31:0] mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_iter #(.XLEN(32), .SHIFT_STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .z(z), .busy(busy));

  alu_iter #(.XLEN(32), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(s4_in_valid), .in_ready(s4_in_ready),
    .funct3(s4_funct3), .funct7(s4_funct7), .rs1(s4_rs1), .rs2(s4_rs2),
    .out_valid(s4_out_valid), .out_ready(s4_out_ready), .rd(s4_rd), .z(s4_z), .busy(s4_busy));

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'd0: return f7[5] ? a - b : a + b;
      3'd1: return a << sh;
`ifdef ALU_ITER_SLT_EN
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
`else
      3'd2: return 32'd0;
      3'd3: return 32'd0;
`endif
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Scoreboard: pop and compare every result the consumer takes.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result rd=%h required no result", rd);
      end else begin
        mon_e = exp_q.pop_front();
        drain_cyc.push_back(cyc);
        if (rd !== mon_e || z !== (mon_e == 32'd0)) begin
          n_err++;
          $display("FAIL result rd=%h z=%b required rd=%h z=%b", rd, z, mon_e, (mon_e == 32'd0));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                      input logic [31:0] b, input logic push, input logic [31:0] ex,
                      output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    in_valid = 1'b1; funct3 = f3; funct7 = f7; rs1 = a; rs2 = b;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
      else begin waited++; step(); end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end else if (push) exp_q.push_back(ex);
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    funct3 = '0; funct7 = '0; rs1 = '0; rs2 = '0;
    s4_in_valid = 1'b0; s4_out_ready = 1'b1;
    s4_funct3 = '0; s4_funct7 = '0; s4_rs1 = '0; s4_rs2 = '0;
    step(); step();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || rd !== 32'd0 || z !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state ov=%b rd=%h z=%b busy=%b ir=%b required 0 0 1 0 1",
               out_valid, rd, z, busy, in_ready);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_midshift();
    int  w;
    logic seen;
    send(3'd1, 7'd0, 32'd1, 32'd20, 1'b0, 32'd0, w);
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL midshift_busy busy=%b required 1", busy); end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || rd !== 32'd0 || z !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midshift ov=%b rd=%h z=%b ir=%b busy=%b required 0 0 1 1 0",
               out_valid, rd, z, in_ready, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    step();
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL reset_abandon out_valid seen=1 required 0"); end
  endtask

  task automatic test_back_to_back();
    int w[4];
    out_ready = 1'b1;
    drain_cyc.delete();
    send(3'd0, 7'h00, 32'd5, 32'd7, 1'b1, 32'd12, w[0]);
    send(3'd0, 7'h20, 32'd3, 32'd3, 1'b1, 32'd0, w[1]);
    send(3'd4, 7'h00, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 32'hF0F0F0F0, w[2]);
    send(3'd7, 7'h00, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 32'd0, w[3]);
    step(); step();
    n_cmp++;
    if (w[1] != 0 || w[2] != 0 || w[3] != 0) begin
      n_err++;
      $display("FAIL b2b_accept_wait waits=%0d,%0d,%0d required 0,0,0", w[1], w[2], w[3]);
    end
    n_cmp++;
    if (drain_cyc.size() != 4) begin
      n_err++;
      $display("FAIL b2b_count results=%0d required 4", drain_cyc.size());
    end else if (drain_cyc[3] - drain_cyc[0] != 3) begin
      n_err++;
      $display("FAIL b2b_spacing span=%0d required 3", drain_cyc[3] - drain_cyc[0]);
    end
  endtask

  task automatic test_shift_latency();
    int   w, lat, busy_cnt;
    logic got;
    send(3'd5, 7'h20, 32'h80000000, 32'd5, 1'b1, 32'hFC000000, w);
    lat = 0; busy_cnt = 0; got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin got = 1'b1; lat = c; end
      else begin
        if (busy === 1'b1) busy_cnt++;
        step();
      end
    end
    n_cmp++;
    if (lat != 6) begin n_err++; $display("FAIL sra_latency lat=%0d required 6", lat); end
    n_cmp++;
    if (busy_cnt != 5 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL sra_busy cycles=%0d end=%b required 5 0", busy_cnt, busy);
    end
    step();
  endtask

  task automatic test_shift_step4();
    int   lat;
    logic got;
    s4_in_valid = 1'b1; s4_funct3 = 3'd1; s4_funct7 = 7'd0; s4_rs1 = 32'd1; s4_rs2 = 32'd31;
    @(negedge clk);
    n_cmp++;
    if (s4_in_ready !== 1'b1) begin n_err++; $display("FAIL s4_ready ir=%b required 1", s4_in_ready); end
    step();
    s4_in_valid = 1'b0;
    lat = 0; got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (s4_out_valid === 1'b1) begin got = 1'b1; lat = c; end
      else step();
    end
    n_cmp++;
    if (lat != 9 || s4_rd !== 32'h80000000 || s4_z !== 1'b0) begin
      n_err++;
      $display("FAIL sll_step4 lat=%0d rd=%h z=%b required 9 80000000 0", lat, s4_rd, s4_z);
    end
    step();
  endtask

  task automatic test_compare();
    int w;
    send(3'd2, 7'd0, 32'hFFFFFFFF, 32'd1, 1'b1,
`ifdef ALU_ITER_SLT_EN
         32'd1,
`else
         32'd0,
`endif
         w);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL slt_latency ov=%b required 1", out_valid); end
    step();
    send(3'd3, 7'd0, 32'hFFFFFFFF, 32'd1, 1'b1, 32'd0, w);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL sltu_latency ov=%b required 1", out_valid); end
    step();
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b0;
    send(3'd6, 7'd0, 32'd1, 32'd2, 1'b1, 32'd3, w);
    in_valid = 1'b1; funct3 = 3'd0; funct7 = 7'd0; rs1 = 32'd10; rs2 = 32'd20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || rd !== 32'd3 || z !== 1'b0 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold ov=%b rd=%h z=%b ir=%b required 1 3 0 0", out_valid, rd, z, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release ir=%b required 1", in_ready); end
    exp_q.push_back(32'd30);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || rd !== 32'd30) begin
      n_err++;
      $display("FAIL bp_next ov=%b rd=%h required 1 0000001e", out_valid, rd);
    end
    step();
  endtask

  task automatic test_edge_shifts();
    int w;
    send(3'd5, 7'd0, 32'h000000A5, 32'd0, 1'b1, 32'h000000A5, w);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL srl0_latency ov=%b busy=%b required 1 0", out_valid, busy);
    end
    step();
    send(3'd1, 7'd0, 32'd3, 32'hFFFFFFE1, 1'b1, 32'd6, w);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL sll1_cycle1 ov=%b busy=%b required 0 1", out_valid, busy);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || rd !== 32'd6) begin
      n_err++;
      $display("FAIL sll1_result ov=%b rd=%h required 1 00000006", out_valid, rd);
    end
    step();
  endtask

  task automatic test_random();
    int          w;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) b = {$urandom_range(0, 1) == 1 ? 27'h7FFFFFF : 27'd0, 5'($urandom_range(0, 3))};
      send(f3, f7, a, b, 1'b1, model(f3, f7, a, b), w);
    end
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) step();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL random_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_midshift();
    test_back_to_back();
    test_shift_latency();
    test_shift_step4();
    test_compare();
    test_backpressure();
    test_edge_shifts();
    test_random();
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised successor to the single-cycle RV32 ALU: executes the full RV32I register-register funct3 set, including SLL/SRL/SRA and SLT/SLTU. Shifts run on an iterative shifter that moves SHIFT_STEP bit positions per cycle. It sits between operand fetch and writeback and uses valid/ready handshakes on both sides. The result and its zero flag are registered and held until writeback accepts them.

## Interface
- XLEN, 32: datapath width; power of two, ≥ 8.
- SHIFT_STEP, 1: maximum bit positions shifted per cycle; 1 ≤ SHIFT_STEP ≤ XLEN.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation presented.
- in_ready  out  1  operation accepted on a clk edge when in_valid && in_ready.
- funct3  in  3  operation select.
- funct7  in  7  only bit 5 is used (SUB/SRA); other bits are ignored.
- rs1, rs2  in  XLEN  operands; sampled only on the accept edge.
- out_valid  out  1  rd/z hold a result.
- out_ready  in  1  consumer takes the result on an edge where out_valid && out_ready.
- rd  out  XLEN  registered result.
- z  out  1  registered; 1 when rd == 0.
- busy  out  1  high while in state SHIFT.

## Operation
- Operations by funct3:
  - 000: ADD, or SUB when funct7[5]=1.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU (unsigned).
  - 100: XOR.
  - 101: SRL, or SRA when funct7[5]=1.
  - 110: OR.
  - 111: AND.
- Arithmetic wraps modulo 2^XLEN; no carry or overflow output.
- SLT/SLTU write 1 or 0, zero-extended to XLEN.
- Shift amount is shamt = rs2[$clog2(XLEN)-1:0]; upper rs2 bits are ignored.
- SRA fills with the sign bit of rs1.
- FSM has two states, IDLE and SHIFT.
- In IDLE, accepting a non-shift op, or a shift with shamt=0, writes rd and z and sets out_valid on the accept edge. State stays IDLE.
- In IDLE, accepting a shift with shamt>0 goes to SHIFT and loads work←rs1, rem←shamt, and the latched op type.
- In SHIFT, on each edge:
  - s = min(SHIFT_STEP, rem); work←work shifted by s; rem←rem−s.
  - When rem−s == 0: rd←shifted value, z updated, out_valid←1, state→IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept and drain may occur on the same edge.
- While out_valid && !out_ready, rd and z are held stable.
- out_valid clears on a drain edge unless a new result is written on that same edge.

## Timing
- Reset values: state IDLE, out_valid 0, rd 0, z 1, busy 0, in_ready 1.
- Latency, accept edge to first cycle with out_valid high:
  - Non-shift op, or shift with shamt=0: 1 cycle.
  - Shift with shamt>0: 1 + ceil(shamt/SHIFT_STEP) cycles.
- Throughput is one op per cycle for non-shift ops when out_ready is held high.
- The iterative shifter is never in the rs1/rs2 → rd path of a single-cycle op; that path is the adder/logic/compare mux only.
- Reset asserted mid-shift abandons the operation immediately. No result is produced and in_ready is 1 in the first cycle after rst_n rises.
- in_valid with in_ready low: no state change. Inputs need not be held; the producer retries.
- SHIFT_STEP=XLEN: every shift with shamt>0 takes exactly 2 cycles.

## Configuration
- ALU_ITER_SLT_EN:
  - Defined: SLT/SLTU behave as in Operation.
  - Undefined: funct3 010/011 complete with latency 1, rd=0, z=1, and the compare logic is not built.

## Test plan
- Reset: assert rst_n=0 mid-shift (SLL rs1=1, shamt=20) → out_valid 0, rd 0, z 1, in_ready 1 after release; no result appears afterwards.
- Back-to-back with out_ready=1: ADD 5+7, SUB 3−3, XOR 0xFF00FF00^0x0FF00FF0, AND 0xF0F0F0F0&0x0F0F0F0F → rd 12, 0 (z=1), 0xF0F0F0F0, 0 (z=1) on 4 consecutive cycles.
- Shift latency, XLEN=32:
  - SHIFT_STEP=1, SRA rs1=0x80000000 shamt=5 → rd 0xFC000000 at cycle 6, busy high cycles 1–5.
  - SHIFT_STEP=4, SLL rs1=1 shamt=31 → rd 0x80000000 at cycle 9.
- Compare (with ALU_ITER_SLT_EN): rs1=0xFFFFFFFF, rs2=1 → SLT rd 1, SLTU rd 0. Without the macro both give rd 0, z 1.
- Backpressure: out_ready=0 for 3 cycles after OR 0x1|0x2 → rd holds 3, in_ready 0, second op is not accepted. Raising out_ready → drain and accept on the same edge; next result follows 1 cycle later.
- Edge shifts: SRL shamt=0 rs1=0xA5 → rd 0xA5 at latency 1. rs2=0xFFFFFFE1 (shamt=1) SLL rs1=3 → rd 6, upper rs2 bits ignored.
